uart_tx_gen: RTL
================

UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 Parameter CLK_DIV, default 868, means clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_W, default 8, means data bits per frame; legal range 5..9.
REQ-003 Parameter STOP_BITS, default 1, means stop bits per frame; legal values 1 or 2.
REQ-004 Parameter PARITY, default 0, means 0 none, 1 odd, 2 even; it is honoured only when UART_TX_PARITY_EN is defined.
REQ-005 clk  input  1  single system clock; all logic is clocked on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 tx_valid  input  1  tx_data holds a word to send.
REQ-008 tx_data  input  DATA_W  word to send, transmitted LSB first.
REQ-009 tx_ready  output  1  holding buffer is empty, so a word can be accepted.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 tx_busy  output  1  a frame is in progress (FSM is not in IDLE).

Function
REQ-012 Transfer: a word is accepted on a rising clk edge where tx_valid=1 and tx_ready=1; tx_data is copied into the one-entry holding buffer; tx_ready is 0 on the next cycle.
REQ-013 Single clock domain: the bit timing comes from an internal baud counter that produces a one-cycle tick; no derived clocks are generated.
REQ-014 FSM states are IDLE, START, DATA, PAR, STOP.
REQ-015 IDLE to START: leave IDLE when the holding buffer is full; on the same edge, move the buffer into the shift register, clear the buffer, and reload the baud counter.
REQ-016 Latency: tx goes low exactly 2 clk cycles after the accepting edge when the FSM was IDLE.
REQ-017 Bit timing: every bit (start, data, parity, stop) lasts exactly CLK_DIV cycles; the baud counter counts from CLK_DIV-1 down to 0, and the tick at 0 advances the FSM.
REQ-018 Transitions: START goes to DATA; DATA goes to PAR after DATA_W bits if parity is enabled and PARITY != 0, otherwise to STOP; PAR goes to STOP; STOP goes to IDLE after STOP_BITS bits.
REQ-019 Back-to-back frames: if the buffer is full at the last STOP tick, the FSM goes directly to START, with no idle gap between frames.
REQ-020 Overlap: a new word can be accepted while a frame is shifting; tx_ready rises the cycle after the buffer moves into the shift register.
REQ-021 Parity bit: the XOR of the data bits, inverted for odd parity.
REQ-022 tx is registered, with no combinational path from tx_valid or tx_data to tx.
REQ-023 Unaccepted data: when tx_valid=1 and tx_ready=0, nothing is captured; tx_data may change freely.

Reset
REQ-024 While rst=1, all of the following are forced immediately, without a clock: tx=1, tx_ready=1, tx_busy=0, FSM=IDLE, buffer empty, baud counter=0.
REQ-025 Reset mid-frame aborts the frame; tx returns high at once, and any buffered word is discarded.
REQ-026 After rst falls, the first word can be accepted on the first rising clk edge.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: the PAR state, the parity generator and the PARITY parameter are compiled in.
REQ-028 Macro UART_TX_PARITY_EN undefined: there is no PAR state or parity logic, PARITY is ignored, and every frame is 8N1-style (start, DATA_W data bits, STOP_BITS stop bits).

Structure
REQ-029 Package uart_pkg holds the FSM state enum, the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), and a function giving frame length in bits.
REQ-030 Sub-module uart_baud_gen (counter with reload and tick output) is instantiated once; the FSM, buffer and shifter stay in uart_tx_gen.

Verification
REQ-031 Basic frame: CLK_DIV=4, DATA_W=8, no parity, tx_data=0xA5 -> tx reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_busy=1 for 40 cycles.
REQ-032 Parity (macro defined): PARITY=2 (even), tx_data=0x07 -> parity bit 1; PARITY=1 (odd) -> parity bit 0.
REQ-033 Back-to-back: 0x55 then 0x0F, second offered during the first frame -> the second start bit follows the first stop bit with no gap, and tx_ready deasserts and reasserts as in REQ-020.
REQ-034 Stall: tx_valid held high while tx_ready=0 -> exactly one extra word is captured, with no duplicates.
REQ-035 Reset mid-frame: assert rst during data bit 3 -> tx=1 in the same cycle, with no stray frame after release.
REQ-036 Options: DATA_W=7, STOP_BITS=2, tx_data=0x41 -> frame is 10 bits with the line high for the last 2 bit times.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice:
//   - tx_state_t   : transmitter FSM state encoding
//   - PAR_NONE/PAR_ODD/PAR_EVEN : parity-mode selector values
//   - frame_bits() : number of bit times in one serial frame
//   - parity_bit() : parity helper (XOR of data, inverted for odd)
// Optional feature macro: UART_TX_PARITY_EN adds the PAR state.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int PAR_NONE = 32'sd0;
   localparam int PAR_ODD  = 32'sd1;
   localparam int PAR_EVEN = 32'sd2;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } tx_state_t;
`endif

   // Bit times per frame: start + data + optional parity + stop bits.
   function automatic int frame_bits(input int data_w, input int stop_bits, input logic par_bit);
      int n;
      n = 32'sd1 + data_w + stop_bits;
      if (par_bit) n = n + 32'sd1;
      else         n = n + 32'sd0;
      return n;
   endfunction

   // Data is zero-extended to 9 bits; zero padding does not change the XOR.
   function automatic logic parity_bit(input logic [8:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Down-counter producing a one-cycle bit tick every CLK_DIV clocks.
// Ports:
//   clk    in  system clock (rising edge)
//   rst    in  asynchronous active-high reset (counter forced to 0)
//   en     in  count while high; counter parks at 0 when low
//   reload in  restart the count at CLK_DIV-1 (highest priority)
//   tick   out high for the single cycle in which the count is 0
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int CLK_DIV = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic reload,
   output logic tick
);

   localparam logic [15:0] RELOAD_VAL = 16'(CLK_DIV - 1);

   logic [15:0] cnt_r;
   logic [15:0] cnt_next_s;
   logic        tick_r;

   // Next count: reload wins, wrap at zero, park at zero when disabled.
   always_comb begin
      cnt_next_s = 16'd0;
      if (reload) begin
         cnt_next_s = RELOAD_VAL;
      end else if (en) begin
         if (cnt_r == 16'd0) cnt_next_s = RELOAD_VAL;
         else                cnt_next_s = cnt_r - 16'd1;
      end else begin
         cnt_next_s = 16'd0;
      end
   end

   // Counter register; tick is registered so it is high exactly while count is 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= 16'd0;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_next_s;
         tick_r <= (en | reload) & (cnt_next_s == 16'd0);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_tx_gen.sv
// -----------------------------------------------------------------------------
// uart_tx_gen
// UART transmitter with a one-entry holding buffer and back-to-back framing.
// Parameters: CLK_DIV (clocks per bit), DATA_W (5..9), STOP_BITS (1..2),
//             PARITY (0 none, 1 odd, 2 even; used only with UART_TX_PARITY_EN).
// Ports:
//   clk      in  system clock (rising edge)
//   rst      in  asynchronous active-high reset
//   tx_valid in  tx_data holds a word to send
//   tx_data  in  word to send, LSB first
//   tx_ready out holding buffer empty
//   tx       out serial line, idle high (registered)
//   tx_busy  out frame in progress
// Optional feature macro: UART_TX_PARITY_EN compiles in the parity bit.
// -----------------------------------------------------------------------------
module uart_tx_gen
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 868,
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx,
   output logic              tx_busy
);

   if ((CLK_DIV < 32'sd2) || (CLK_DIV > 32'sd65535) || (DATA_W < 32'sd5) || (DATA_W > 32'sd9) ||
       (STOP_BITS < 32'sd1) || (STOP_BITS > 32'sd2) || (PARITY < 32'sd0) || (PARITY > 32'sd2))
   begin : g_bad_param
      $error("uart_tx_gen: parameter out of legal range");
   end

   localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_ON  = (PARITY != PAR_NONE);
   localparam logic ODD_SEL = (PARITY == PAR_ODD);
   logic par_r;
`endif

   tx_state_t         state_r;
   logic [DATA_W-1:0] buf_r;
   logic [DATA_W-1:0] shift_r;
   logic [3:0]        bit_cnt_r;
   logic              buf_full_r;
   logic              tx_ready_r;
   logic              tx_busy_r;
   logic              tx_r;

   logic tick_s;
   logic accept_s;
   logic stop_done_s;
   logic load_s;
   logic baud_en_s;

   // Handshake and frame-boundary decodes.
   always_comb begin
      accept_s    = tx_valid & tx_ready_r;
      stop_done_s = (state_r == ST_STOP) & tick_s & (bit_cnt_r == LAST_STOP);
      // The buffer moves to the shifter from IDLE, or straight off the last
      // stop tick so consecutive frames touch with no idle gap.
      load_s      = buf_full_r & ((state_r == ST_IDLE) | stop_done_s);
      baud_en_s   = (state_r != ST_IDLE);
   end

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .en     (baud_en_s),
      .reload (load_s),
      .tick   (tick_s)
   );

   // Transmit FSM, holding buffer, shifter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         buf_r      <= '0;
         shift_r    <= '0;
         bit_cnt_r  <= 4'd0;
         buf_full_r <= 1'b0;
         tx_ready_r <= 1'b1;
         tx_busy_r  <= 1'b0;
         tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_r      <= 1'b0;
`endif
      end else begin
         // The line follows the state one cycle later, which gives the
         // two-cycle accept-to-start latency while keeping every bit CLK_DIV long.
         case (state_r)
            ST_IDLE:  tx_r <= 1'b1;
            ST_START: tx_r <= 1'b0;
            ST_DATA:  tx_r <= shift_r[0];
`ifdef UART_TX_PARITY_EN
            ST_PAR:   tx_r <= par_r;
`endif
            ST_STOP:  tx_r <= 1'b1;
            default:  tx_r <= 1'b1;
         endcase

         if (load_s) begin
            buf_full_r <= 1'b0;
            tx_ready_r <= 1'b1;
            shift_r    <= buf_r;
            bit_cnt_r  <= 4'd0;
`ifdef UART_TX_PARITY_EN
            par_r      <= parity_bit(9'(buf_r), ODD_SEL);
`endif
         end else if (accept_s) begin
            buf_r      <= tx_data;
            buf_full_r <= 1'b1;
            tx_ready_r <= 1'b0;
         end else begin
            tx_ready_r <= ~buf_full_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (load_s) begin
                  state_r   <= ST_START;
                  tx_busy_r <= 1'b1;
               end
            end
            ST_START: begin
               if (tick_s) begin
                  state_r   <= ST_DATA;
                  bit_cnt_r <= 4'd0;
               end
            end
            ST_DATA: begin
               if (tick_s) begin
                  shift_r <= {1'b0, shift_r[DATA_W-1:1]};
                  if (bit_cnt_r == LAST_DATA) begin
                     bit_cnt_r <= 4'd0;
`ifdef UART_TX_PARITY_EN
                     state_r   <= PAR_ON ? ST_PAR : ST_STOP;
`else
                     state_r   <= ST_STOP;
`endif
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PAR: begin
               if (tick_s) begin
                  state_r   <= ST_STOP;
                  bit_cnt_r <= 4'd0;
               end
            end
`endif
            ST_STOP: begin
               if (stop_done_s) begin
                  // Shifter/counter reload for a waiting word happens via load_s above.
                  if (buf_full_r) begin
                     state_r <= ST_START;
                  end else begin
                     state_r   <= ST_IDLE;
                     tx_busy_r <= 1'b0;
                     bit_cnt_r <= 4'd0;
                  end
               end else if (tick_s) begin
                  bit_cnt_r <= bit_cnt_r + 4'd1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               tx_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready = tx_ready_r;
   assign tx       = tx_r;
   assign tx_busy  = tx_busy_r;

endmodule
